// File: rtl/fft_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shazam_pkg
// Description : Shared defaults, scheduler state type and saturating helper
//               for the FFT frame scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package shazam_pkg;

    localparam int ADC_W_DEFAULT     = 12;
    localparam int FRAME_LEN_DEFAULT = 1024;
    localparam int NUM_FFT_DEFAULT   = 3;
    localparam int OVERRUN_W         = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        STREAM = 2'd2,
        DROP   = 2'd3
    } sched_state_t;

    function automatic logic [OVERRUN_W-1:0] sat_inc(input logic [OVERRUN_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_frame_scheduler_busy_tracker.sv
`default_nettype none
// ============================================================================
// Module      : fft_busy_tracker
// Description : Per-engine busy flags with set-wins priority, same-cycle done
//               bypass for the free query, and an all-busy view.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_busy_tracker
    import shazam_pkg::*;
#(
    parameter int NUM_FFT = NUM_FFT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_all,
    input  logic                       set_en,
    input  logic [$clog2(NUM_FFT)-1:0] set_idx,
    input  logic [NUM_FFT-1:0]         done,
    input  logic [$clog2(NUM_FFT)-1:0] query_idx,
    output logic                       query_free,
    output logic                       all_busy
);

    localparam int c_idx_w = $clog2(NUM_FFT);

    logic [NUM_FFT-1:0] r_busy;

    for (genvar gi = 0; gi < NUM_FFT; gi++) begin : g_flag
        // Set is checked before done so a grant on the same cycle as a done wins.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_busy[gi] <= 1'b0;
            end else if (clear_all) begin
                r_busy[gi] <= 1'b0;
            end else if (set_en && (set_idx == c_idx_w'(gi))) begin
                r_busy[gi] <= 1'b1;
            end else if (done[gi]) begin
                r_busy[gi] <= 1'b0;
            end
        end
    end

    // An engine finishing this very cycle can accept the next frame immediately.
    assign query_free = ~r_busy[query_idx] | done[query_idx];
    assign all_busy   = &r_busy;

endmodule
`default_nettype wire

// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_scheduler
// Description : Cuts the ADC sample stream into frames and hands each frame to
//               the FFT engines in strict round-robin order, dropping frames
//               whose target engine is still busy.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_scheduler
    import shazam_pkg::*;
#(
    parameter int NUM_FFT   = NUM_FFT_DEFAULT,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int ADC_W     = ADC_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [ADC_W-1:0]           sample_in,
    input  logic                       sample_valid,
    input  logic [NUM_FFT-1:0]         fft_done,
    output logic [ADC_W-1:0]           sample_out,
    output logic [NUM_FFT-1:0]         write_active,
    output logic [NUM_FFT-1:0]         fft_clear,
    output logic                       frame_start,
    output logic                       frame_last,
    output logic [$clog2(NUM_FFT)-1:0] frame_engine,
    output logic                       all_busy,
    output logic [OVERRUN_W-1:0]       overrun_count
);

    localparam int c_idx_w = $clog2(NUM_FFT);
    localparam int c_cnt_w = $clog2(FRAME_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [c_idx_w-1:0] c_ptr_last = c_idx_w'(NUM_FFT - 1);

    sched_state_t r_state, w_state_next;
    logic [c_idx_w-1:0]   r_ptr, w_ptr_next;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic [ADC_W-1:0]     r_sample_out;
    logic [NUM_FFT-1:0]   r_write_active, w_write_active_next;
    logic [NUM_FFT-1:0]   r_fft_clear, w_fft_clear_next;
    logic                 r_frame_start, w_frame_start_next;
    logic                 r_frame_last, w_frame_last_next;
    logic [c_idx_w-1:0]   r_frame_engine, w_frame_engine_next;
    logic [OVERRUN_W-1:0] r_overrun, w_overrun_next;

    logic [NUM_FFT-1:0]   w_ptr_onehot;
    logic [NUM_FFT-1:0]   w_done_eff;
    logic                 w_set_en;
    logic                 w_clear_all;
    logic                 w_free;

    assign w_ptr_onehot = {{(NUM_FFT-1){1'b0}}, 1'b1} << r_ptr;

    // A done from the engine being fed is a protocol violation and is ignored.
    assign w_done_eff = fft_done & ~((r_state == STREAM) ? w_ptr_onehot : '0);

    fft_busy_tracker #(
        .NUM_FFT (NUM_FFT)
    ) u_busy (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_all  (w_clear_all),
        .set_en     (w_set_en),
        .set_idx    (r_ptr),
        .done       (w_done_eff),
        .query_idx  (r_ptr),
        .query_free (w_free),
        .all_busy   (all_busy)
    );

    always_comb begin
        w_state_next        = r_state;
        w_ptr_next          = r_ptr;
        w_cnt_next          = r_cnt;
        w_write_active_next = '0;
        w_frame_start_next  = 1'b0;
        w_frame_last_next   = 1'b0;
        w_frame_engine_next = r_frame_engine;
        w_overrun_next      = r_overrun;
        w_set_en            = 1'b0;
        w_clear_all         = 1'b0;

        if (r_state == IDLE) begin
            w_clear_all = 1'b1;
            if (enable) begin
                w_state_next = SEEK;
            end
        end else if (!enable) begin
            w_state_next = IDLE;
            w_ptr_next   = '0;
            w_cnt_next   = '0;
            w_clear_all  = 1'b1;
        end else begin
            case (r_state)
                SEEK: begin
                    if (sample_valid) begin
                        w_cnt_next = c_cnt_w'(1);
                        if (w_free) begin
                            w_set_en            = 1'b1;
                            w_state_next        = STREAM;
                            w_write_active_next = w_ptr_onehot;
                            w_frame_start_next  = 1'b1;
                            w_frame_engine_next = r_ptr;
                        end else begin
                            w_state_next = DROP;
                        end
                    end
                end
                STREAM: begin
                    if (sample_valid) begin
                        w_write_active_next = w_ptr_onehot;
                        w_cnt_next          = r_cnt + 1'b1;
                        if (r_cnt == c_cnt_last) begin
                            w_frame_last_next = 1'b1;
                            w_ptr_next        = (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
                            w_state_next      = SEEK;
                        end
                    end
                end
                DROP: begin
                    // Pointer is held so the same engine is retried and order survives.
                    if (sample_valid) begin
                        w_cnt_next = r_cnt + 1'b1;
                        if (r_cnt == c_cnt_last) begin
                            w_overrun_next = sat_inc(r_overrun);
                            w_state_next   = SEEK;
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end

        w_fft_clear_next = {NUM_FFT{w_state_next == IDLE}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_sample_out   <= '0;
            r_write_active <= '0;
            r_fft_clear    <= '0;
            r_frame_start  <= 1'b0;
            r_frame_last   <= 1'b0;
            r_frame_engine <= '0;
            r_overrun      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_ptr          <= w_ptr_next;
            r_cnt          <= w_cnt_next;
            r_sample_out   <= sample_in;
            r_write_active <= w_write_active_next;
            r_fft_clear    <= w_fft_clear_next;
            r_frame_start  <= w_frame_start_next;
            r_frame_last   <= w_frame_last_next;
            r_frame_engine <= w_frame_engine_next;
            r_overrun      <= w_overrun_next;
        end
    end

    assign sample_out    = r_sample_out;
    assign write_active  = r_write_active;
    assign fft_clear     = r_fft_clear;
    assign frame_start   = r_frame_start;
    assign frame_last    = r_frame_last;
    assign frame_engine  = r_frame_engine;
    assign overrun_count = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_scheduler
// Description : Scoreboard bench for fft_frame_scheduler with a frame-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_scheduler;

    localparam int N = 3;
    localparam int L = 8;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic [N-1:0] fft_done = '0;

    logic [W-1:0] sample_out;
    logic [N-1:0] write_active;
    logic [N-1:0] fft_clear;
    logic         frame_start;
    logic         frame_last;
    logic [1:0]   frame_engine;
    logic         all_busy;
    logic [15:0]  overrun_count;

    fft_frame_scheduler #(
        .NUM_FFT   (N),
        .FRAME_LEN (L),
        .ADC_W     (W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sample_in     (sample_in),
        .sample_valid  (sample_valid),
        .fft_done      (fft_done),
        .sample_out    (sample_out),
        .write_active  (write_active),
        .fft_clear     (fft_clear),
        .frame_start   (frame_start),
        .frame_last    (frame_last),
        .frame_engine  (frame_engine),
        .all_busy      (all_busy),
        .overrun_count (overrun_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           due;
        logic [N-1:0] wa;
        logic [N-1:0] clr;
        logic [1:0]   eng;
        logic         ab;
        logic [15:0]  ovr;
    } stat_t;

    typedef struct {
        logic [W-1:0] s;
        logic         fs;
        logic         fl;
    } wr_t;

    stat_t sq[$];
    wr_t   wq[$];

    int n_vec = 0;
    int n_err = 0;
    bit mon_on = 1'b0;

    // Reference model: frame position bookkeeping, not a state machine copy.
    bit         m_run;
    bit         m_in_frame;
    int         m_target;
    int         m_pos;
    int         m_next;
    bit [N-1:0] m_busy;
    int         m_ovr;
    int         m_eng;

    task automatic model_reset();
        m_run = 0; m_in_frame = 0; m_target = -1; m_pos = 0;
        m_next = 0; m_busy = '0; m_ovr = 0; m_eng = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit en, input bit v, input logic [N-1:0] done);
        stat_t      st;
        wr_t        wr;
        logic [N-1:0] wa;
        bit         fs, fl;
        @(posedge clk);
        #1;
        enable       = en;
        sample_valid = v;
        sample_in    = W'($urandom);
        fft_done     = done;
        wa = '0; fs = 0; fl = 0;
        if (!m_run) begin
            if (en) m_run = 1;
        end else if (!en) begin
            m_run = 0; m_busy = '0; m_next = 0; m_in_frame = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (done[i] && !(m_in_frame && m_target == i)) m_busy[i] = 1'b0;
            if (v) begin
                if (!m_in_frame) begin
                    m_in_frame = 1; m_pos = 0;
                    if (!m_busy[m_next]) begin
                        m_target = m_next; m_busy[m_next] = 1'b1; fs = 1; m_eng = m_next;
                    end else begin
                        m_target = -1;
                    end
                end
                if (m_target >= 0) begin
                    wa[m_target] = 1'b1;
                    fl = (m_pos == L - 1);
                end else if (m_pos == L - 1 && m_ovr < 65535) begin
                    m_ovr++;
                end
                m_pos++;
                if (m_pos == L) begin
                    m_in_frame = 0;
                    if (m_target >= 0) m_next = (m_next + 1) % N;
                end
            end
        end
        st.due = cyc + 1;
        st.wa  = wa;
        st.clr = m_run ? '0 : '1;
        st.eng = 2'(m_eng);
        st.ab  = &m_busy;
        st.ovr = 16'(m_ovr);
        sq.push_back(st);
        if (wa != '0) begin
            wr.s = sample_in; wr.fs = fs; wr.fl = fl;
            wq.push_back(wr);
        end
    endtask

    task automatic settle(input bit en);
        step(en, 1'b0, '0);
        @(negedge clk);
        #1;
    endtask

    stat_t e;
    wr_t   w;
    always @(negedge clk) begin
        if (mon_on) begin
            while (sq.size() > 0 && sq[0].due <= cyc) begin
                e = sq.pop_front();
                chk("write_active",  32'(write_active),  32'(e.wa));
                chk("fft_clear",     32'(fft_clear),     32'(e.clr));
                chk("frame_engine",  32'(frame_engine),  32'(e.eng));
                chk("all_busy",      32'(all_busy),      32'(e.ab));
                chk("overrun_count", 32'(overrun_count), 32'(e.ovr));
            end
            if (write_active != '0) begin
                chk("write_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    chk("sample_out",  32'(sample_out),  32'(w.s));
                    chk("frame_start", 32'(frame_start), 32'(w.fs));
                    chk("frame_last",  32'(frame_last),  32'(w.fl));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_sample_out"},    32'(sample_out),    0);
        chk({tag, "_write_active"},  32'(write_active),  0);
        chk({tag, "_fft_clear"},     32'(fft_clear),     0);
        chk({tag, "_frame_start"},   32'(frame_start),   0);
        chk({tag, "_frame_last"},    32'(frame_last),    0);
        chk({tag, "_frame_engine"},  32'(frame_engine),  0);
        chk({tag, "_all_busy"},      32'(all_busy),      0);
        chk({tag, "_overrun_count"}, 32'(overrun_count), 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        step(0, 0, '0);
        step(0, 0, '0);

        // Three back-to-back frames fill every engine.
        step(1, 0, '0);
        repeat (24) step(1, 1, '0);
        settle(1);
        chk("fill_all_busy", 32'(all_busy), 1);
        chk("fill_engine",   32'(frame_engine), 2);
        chk("fill_overrun",  32'(overrun_count), 0);

        // Next frame targets busy engine 0 and is dropped.
        repeat (8) step(1, 1, '0);
        settle(1);
        chk("drop_overrun", 32'(overrun_count), 1);
        chk("drop_engine",  32'(frame_engine), 2);

        // Engine 0 released, same engine retried.
        step(1, 0, 3'b001);
        repeat (8) step(1, 1, '0);
        settle(1);
        chk("retry_engine", 32'(frame_engine), 0);

        // Walk round to engine 0 while it is busy, then done on the first sample.
        step(1, 0, 3'b110);
        repeat (16) step(1, 1, '0);
        step(1, 1, 3'b001);
        repeat (7) step(1, 1, '0);
        settle(1);
        chk("bypass_overrun", 32'(overrun_count), 1);
        chk("bypass_engine",  32'(frame_engine), 0);

        // Gapped frame: valid every third cycle.
        step(1, 0, 3'b010);
        for (int i = 0; i < L; i++) begin
            step(1, 1, '0);
            step(1, 0, '0);
            step(1, 0, '0);
        end
        settle(1);
        chk("gapped_engine", 32'(frame_engine), 1);

        // Enable dropped after four samples of a frame.
        step(1, 0, 3'b100);
        repeat (4) step(1, 1, '0);
        step(0, 0, '0);
        settle(0);
        chk("abort_clear",    32'(fft_clear), 3'b111);
        chk("abort_busy",     32'(all_busy), 0);
        chk("abort_write",    32'(write_active), 0);
        step(1, 0, '0);
        repeat (8) step(1, 1, '0);
        settle(1);
        chk("reenable_engine",  32'(frame_engine), 0);
        chk("reenable_overrun", 32'(overrun_count), 1);

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            logic [N-1:0] d;
            for (int b = 0; b < N; b++) d[b] = ($urandom_range(0, 99) < 8);
            step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 75), d);
        end
        settle(1);
        chk("write_queue_drained", 32'(wq.size()), 0);

        // Async reset between edges while streaming.
        step(0, 0, '0);
        step(1, 0, '0);
        repeat (3) step(1, 1, '0);
        @(posedge clk);
        #2;
        chk("pre_reset_writing", 32'(write_active != '0), 1);
        mon_on = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sq.delete();
        wq.delete();
        enable = 1'b0; sample_valid = 1'b0; fft_done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
